// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for a 32x8 read-first register file: round-robin arbitration
// between two write requesters, a registered write stage, and same-edge read forwarding.
module regfile_wr_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr1,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr2,
  input  logic [DATA_WIDTH-1:0] rf_rd_data1,
  input  logic [DATA_WIDTH-1:0] rf_rd_data2
);

  logic                  ptr_q, ptr_d;
  logic                  grant0, grant1, accept, acc_drop;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;

  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  hit1_q, hit1_d, hit2_q, hit2_d;
  logic                  zero1_q, zero1_d, zero2_q, zero2_d;
  logic [DATA_WIDTH-1:0] fwd1_q, fwd2_q;

  // ptr_q = 0 gives requester 0 priority when both are valid
  always_comb begin
    grant0   = req0_valid & (~req1_valid | ~ptr_q);
    grant1   = req1_valid & (~req0_valid | ptr_q);
    accept   = grant0 | grant1;
    acc_addr = grant0 ? req0_addr : req1_addr;
    acc_data = grant0 ? req0_data : req1_data;
    acc_drop = (ZERO_REG != 0) && (acc_addr == '0);

    ptr_d   = accept ? grant0 : ptr_q;
    wen_d   = accept & ~acc_drop;
    waddr_d = accept ? acc_addr : waddr_q;
    wdata_d = accept ? acc_data : wdata_q;

    hit1_d  = wen_q & (waddr_q == rd_addr1);
    hit2_d  = wen_q & (waddr_q == rd_addr2);
    zero1_d = (ZERO_REG != 0) && (rd_addr1 == '0);
    zero2_d = (ZERO_REG != 0) && (rd_addr2 == '0);
  end

  // zero flags come out of reset set so the read ports show 0 until the first sampling edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hit1_q  <= 1'b0;
      hit2_q  <= 1'b0;
      fwd1_q  <= '0;
      fwd2_q  <= '0;
      zero1_q <= 1'b1;
      zero2_q <= 1'b1;
    end else begin
      ptr_q   <= ptr_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hit1_q  <= hit1_d;
      hit2_q  <= hit2_d;
      fwd1_q  <= wdata_q;
      fwd2_q  <= wdata_q;
      zero1_q <= zero1_d;
      zero2_q <= zero2_d;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign rf_wen      = wen_q;
  assign rf_wr_addr  = waddr_q;
  assign rf_wr_data  = wdata_q;
  assign rf_rd_addr1 = rd_addr1;
  assign rf_rd_addr2 = rd_addr2;

  assign rd_data1 = zero1_q ? '0 : (hit1_q ? fwd1_q : rf_rd_data1);
  assign rd_data2 = zero2_q ? '0 : (hit2_q ? fwd2_q : rf_rd_data2);

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Bench for regfile_wr_sched: a read-first register file model drives the read data back,
// and an architectural model predicts grants, write-stage outputs and read results.
module tb_regfile_wr_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [4:0] req0_addr = '0, req1_addr = '0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic [4:0] rd_addr1 = '0, rd_addr2 = '0;
  logic [7:0] rd_data1, rd_data2;
  logic       rf_wen;
  logic [4:0] rf_wr_addr, rf_rd_addr1, rf_rd_addr2;
  logic [7:0] rf_wr_data;
  logic [7:0] rf_rd_data1 = '0, rf_rd_data2 = '0;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  regfile_wr_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rf_wen(rf_wen), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2)
  );

  always #5 clk = ~clk;

  // external register file: read-first, one-cycle read latency, unaffected by reset
  logic [7:0] rf_mem [32];
  always @(posedge clk) begin
    rf_rd_data1 <= rf_mem[rf_rd_addr1];
    rf_rd_data2 <= rf_mem[rf_rd_addr2];
    if (rf_wen) rf_mem[rf_wr_addr] <= rf_wr_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // architectural model: register contents as seen by software, plus the pending write
  logic [7:0] m_mem [32];
  int         m_ptr = 0;
  bit         m_wen = 1'b0;
  logic [4:0] m_waddr = '0;
  logic [7:0] m_wdata = '0;
  logic [7:0] e_rd1 = '0, e_rd2 = '0;

  function automatic int exp_grant();
    if (req0_valid && req1_valid) return m_ptr;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    int g;
    logic [4:0] a;
    if (!rst) begin
      m_ptr = 0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0; e_rd1 = '0; e_rd2 = '0;
    end else begin
      g = exp_grant();
      if (m_wen) m_mem[m_waddr] = m_wdata;
      e_rd1 = (rd_addr1 == 5'd0) ? 8'h00 : m_mem[rd_addr1];
      e_rd2 = (rd_addr2 == 5'd0) ? 8'h00 : m_mem[rd_addr2];
      if (g >= 0) begin
        a       = (g == 0) ? req0_addr : req1_addr;
        m_wdata = (g == 0) ? req0_data : req1_data;
        m_waddr = a;
        m_wen   = (a != 5'd0);
        m_ptr   = 1 - g;
      end else begin
        m_wen = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    if (chk_en) begin
      g = exp_grant();
      chk("req0_ready", 32'(req0_ready), 32'(g == 0));
      chk("req1_ready", 32'(req1_ready), 32'(g == 1));
      chk("one_ready", 32'(req0_ready & req1_ready), 32'(0));
      chk("rf_wen", 32'(rf_wen), 32'(m_wen));
      chk("rf_wr_addr", 32'(rf_wr_addr), 32'(m_waddr));
      chk("rf_wr_data", 32'(rf_wr_data), 32'(m_wdata));
      chk("rd_data1", 32'(rd_data1), 32'(e_rd1));
      chk("rd_data2", 32'(rd_data2), 32'(e_rd2));
      chk("rf_rd_addr1", 32'(rf_rd_addr1), 32'(rd_addr1));
      chk("rf_rd_addr2", 32'(rf_rd_addr2), 32'(rd_addr2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gr [4];
    int exp_g [4] = '{0, 1, 0, 1};
    logic [7:0] v;
    for (int i = 0; i < 32; i++) begin
      v = (i == 7) ? 8'h11 : (i == 9) ? 8'h00 : (i == 5) ? 8'h66 : 8'(i * 7 + 1);
      rf_mem[i] = v;
      m_mem[i]  = v;
    end
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset_wen", 32'(rf_wen), 32'(0));
    chk("reset_rd1", 32'(rd_data1), 32'(0));
    chk("reset_rd2", 32'(rd_data2), 32'(0));
    tick();
    rst = 1'b1;

    // both requesters valid: round-robin from requester 0
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 8'h10 + 8'(k);
      req1_valid = 1'b1; req1_addr = 5'd20; req1_data = 8'h20 + 8'(k);
      @(negedge clk);
      gr[k] = req0_ready ? 0 : (req1_ready ? 1 : 9);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) chk($sformatf("rr_grant%0d", k), 32'(gr[k]), 32'(exp_g[k]));
    tick();

    // single request: write stage one cycle after accept
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 8'h5A;
    @(negedge clk);
    chk("t1_ready", 32'(req0_ready), 32'(1));
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_wen", 32'(rf_wen), 32'(1));
    chk("t1_addr", 32'(rf_wr_addr), 32'(3));
    chk("t1_data", 32'(rf_wr_data), 32'(8'h5A));
    tick();
    @(negedge clk);
    chk("t1_wen_off", 32'(rf_wen), 32'(0));

    // both read ports hit the write-stage address
    tick();
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 8'hC3;
    tick();
    req1_valid = 1'b0; rd_addr1 = 5'd7; rd_addr2 = 5'd7;
    tick();
    @(negedge clk);
    chk("t3_rf_stale", 32'(rf_rd_data1), 32'(8'h11));
    chk("t3_rd1", 32'(rd_data1), 32'(8'hC3));
    chk("t3_rd2", 32'(rd_data2), 32'(8'hC3));

    // read in the accept cycle sees old data, one cycle later sees new
    tick();
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 8'h44; rd_addr1 = 5'd9; rd_addr2 = 5'd3;
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t4_old", 32'(rd_data1), 32'(8'h00));
    chk("t4_rd2", 32'(rd_data2), 32'(8'h5A));
    tick();
    @(negedge clk);
    chk("t4_new", 32'(rd_data1), 32'(8'h44));

    // write to register 0 is handshaken but dropped
    tick();
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 8'hFF; rd_addr1 = 5'd0;
    @(negedge clk);
    chk("t5_ready", 32'(req1_ready), 32'(1));
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("t5_wen", 32'(rf_wen), 32'(0));
    chk("t5_rd1", 32'(rd_data1), 32'(0));

    // back-to-back accepts to the same address
    tick();
    rd_addr1 = 5'd15; rd_addr2 = 5'd15;
    req0_valid = 1'b1; req0_addr = 5'd15; req0_data = 8'h31;
    req1_valid = 1'b1; req1_addr = 5'd15; req1_data = 8'h32;
    repeat (2) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("t7_last", 32'(rd_data1), 32'(8'h32));

    // reset during the write stage discards the write and the pointer
    tick();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 8'h99;
    tick();
    req0_valid = 1'b0;
    #1 rst = 1'b0;
    #1 chk("t6_wen_drop", 32'(rf_wen), 32'(0));
    tick();
    rst = 1'b1; rd_addr1 = 5'd5;
    req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 8'h77;
    req1_valid = 1'b1; req1_addr = 5'd13; req1_data = 8'h88;
    @(negedge clk);
    chk("t6_ptr_r0", 32'(req0_ready), 32'(1));
    chk("t6_ptr_r1", 32'(req1_ready), 32'(0));
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("t6_rd5", 32'(rd_data1), 32'(8'h66));
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
